trig_capture_ctrl: RTL and testbench

Capture sequencer for the logic-analyzer front end. It holds trigger configuration and drives the UART byte-trigger's baud/match/mask inputs. It gates sample writes into a circular capture RAM, arms on command and fills a programmable pre-trigger window. It then waits for any enabled trigger source, counts the post-trigger samples, and flags completion with the trigger address so readout can unroll the buffer.

---
 rtl/trig_capture_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_trig_capture_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_capture_ctrl.sv
// -----------------------------------------------------------------------------
// trig_capture_ctrl
//
// Capture sequencer for the logic-analyzer front end. It holds the trigger
// configuration and drives the UART byte-trigger's baud, match and mask
// inputs. It gates sample writes into a circular capture RAM. On arm it fills
// a programmable pre-trigger window, then waits for any enabled trigger
// source. After the trigger it counts post-trigger samples until the buffer
// holds DEPTH samples in total. It then flags completion and reports the
// trigger address, so readout can unroll the ring.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   cfg_wr/addr/wdata  config write port (0 baud, 1 {mask,match},
//                      2 trig_en, 3 trig_pos); accepted only in IDLE/DONE
//   arm, abort      one-cycle capture start / cancel pulses
//   smpl_en         sample strobe from the decimator
//   trig_src        trigger pulses, bit 0 = UART byte trigger
//   uart_baud_cnt/uart_match/uart_mask  UART trigger configuration
//   wr_en, wr_addr  capture RAM write port (wr_en is combinational)
//   trig_addr       RAM address of the trigger sample
//   armed           high in PRE, WAIT or POST
//   capture_done    high in DONE
// -----------------------------------------------------------------------------
module trig_capture_ctrl #(
  parameter int ADDR_W = 9,
  parameter int N_SRC  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_wr,
  input  logic [1:0]        cfg_addr,
  input  logic [15:0]       cfg_wdata,
  input  logic              arm,
  input  logic              abort,
  input  logic              smpl_en,
  input  logic [N_SRC-1:0]  trig_src,
  output logic [15:0]       uart_baud_cnt,
  output logic [7:0]        uart_match,
  output logic [7:0]        uart_mask,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              armed,
  output logic              capture_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_WAIT,
    S_POST,
    S_DONE
  } state_e;

  // DEPTH expressed in the post counter's width (ADDR_W+1 bits).
  localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_V   = {{ADDR_W{1'b0}}, 1'b1};

  state_e             state_q,     state_d;
  logic [15:0]        baud_q,      baud_d;
  logic [7:0]         match_q,     match_d;
  logic [7:0]         mask_q,      mask_d;
  logic [N_SRC-1:0]   trig_en_q,   trig_en_d;
  logic [ADDR_W-1:0]  trig_pos_q,  trig_pos_d;
  logic [ADDR_W-1:0]  wr_addr_q,   wr_addr_d;
  logic [ADDR_W-1:0]  trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0]  pre_cnt_q,   pre_cnt_d;
  logic [ADDR_W:0]    post_cnt_q,  post_cnt_d;
  logic               armed_q,     armed_d;
  logic               done_q,      done_d;

  logic               capturing;
  logic               hit;
  logic [ADDR_W-1:0]  pre_cnt_inc;
  logic [ADDR_W:0]    post_cnt_inc;
  logic [ADDR_W:0]    post_target;

  assign capturing    = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  // abort wins over a coincident sample, so no write lands in the abort cycle.
  assign wr_en        = smpl_en && capturing && !abort;
  assign hit          = |(trig_src & trig_en_q);
  assign pre_cnt_inc  = pre_cnt_q + 1'b1;
  assign post_cnt_inc = post_cnt_q + 1'b1;
  // Post samples needed so that pre + post fills the whole ring exactly once.
  assign post_target  = DEPTH_V - {1'b0, trig_pos_q};

  always_comb begin
    // NOTE: every _d starts as its _q so each path below only names what it
    // changes; without these defaults the missing branches would infer latches.
    state_d     = state_q;
    baud_d      = baud_q;
    match_d     = match_q;
    mask_d      = mask_q;
    trig_en_d   = trig_en_q;
    trig_pos_d  = trig_pos_q;
    wr_addr_d   = wr_addr_q;
    trig_addr_d = trig_addr_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;

    // Config is locked while a capture is in flight.
    if (cfg_wr && !capturing) begin
      case (cfg_addr)
        2'd0:    baud_d = cfg_wdata;
        2'd1:    {mask_d, match_d} = cfg_wdata;
        2'd2:    trig_en_d = cfg_wdata[N_SRC-1:0];
        default: trig_pos_d = cfg_wdata[ADDR_W-1:0];
      endcase
    end

    // Natural wrap DEPTH-1 -> 0 from the ADDR_W-bit add.
    if (wr_en) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            wr_addr_d  = '0;
            pre_cnt_d  = '0;
            post_cnt_d = '0;
            state_d    = (trig_pos_q == '0) ? S_WAIT : S_PRE;
          end
        end
        S_PRE: begin
          if (wr_en) begin
            pre_cnt_d = pre_cnt_inc;
            if (pre_cnt_inc == trig_pos_q) begin
              state_d = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (hit) begin
            trig_addr_d = wr_addr_q;
            if (smpl_en) begin
              // The trigger-cycle sample is post sample 1 and may complete
              // the capture on its own.
              post_cnt_d = ONE_V;
              state_d    = (post_target == ONE_V) ? S_DONE : S_POST;
            end else begin
              post_cnt_d = '0;
              state_d    = S_POST;
            end
          end
        end
        S_POST: begin
          if (wr_en) begin
            post_cnt_d = post_cnt_inc;
            if (post_cnt_inc == post_target) begin
              state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    armed_d = (state_d == S_PRE) || (state_d == S_WAIT) || (state_d == S_POST);
    done_d  = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      baud_q      <= '0;
      match_q     <= '0;
      mask_q      <= '0;
      trig_en_q   <= '0;
      trig_pos_q  <= '0;
      wr_addr_q   <= '0;
      trig_addr_q <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      match_q     <= match_d;
      mask_q      <= mask_d;
      trig_en_q   <= trig_en_d;
      trig_pos_q  <= trig_pos_d;
      wr_addr_q   <= wr_addr_d;
      trig_addr_q <= trig_addr_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
    end
  end

  assign uart_baud_cnt = baud_q;
  assign uart_match    = match_q;
  assign uart_mask     = mask_q;
  assign wr_addr       = wr_addr_q;
  assign trig_addr     = trig_addr_q;
  assign armed         = armed_q;
  assign capture_done  = done_q;

endmodule

// File: tb/tb_trig_capture_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trig_capture_ctrl
//
// Self-checking bench for trig_capture_ctrl with ADDR_W=4 (DEPTH=16).
// Directed scenarios cover configuration, normal capture, trig_pos=0,
// masking, the PRE guard, abort, config lockout, sparse sampling and reset
// mid-capture. A randomized phase follows. Every cycle all outputs are
// compared against a reference model. The model describes a capture as
// "samples still owed" (pre samples left, then post samples left) rather
// than as a state machine.
// -----------------------------------------------------------------------------
module tb_trig_capture_ctrl;

  localparam int ADDR_W = 4;
  localparam int N_SRC  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cfg_wr;
  logic [1:0]        cfg_addr;
  logic [15:0]       cfg_wdata;
  logic              arm;
  logic              abort;
  logic              smpl_en;
  logic [N_SRC-1:0]  trig_src;
  logic [15:0]       uart_baud_cnt;
  logic [7:0]        uart_match;
  logic [7:0]        uart_mask;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] trig_addr;
  logic              armed;
  logic              capture_done;

  trig_capture_ctrl #(.ADDR_W(ADDR_W), .N_SRC(N_SRC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_wr        (cfg_wr),
    .cfg_addr      (cfg_addr),
    .cfg_wdata     (cfg_wdata),
    .arm           (arm),
    .abort         (abort),
    .smpl_en       (smpl_en),
    .trig_src      (trig_src),
    .uart_baud_cnt (uart_baud_cnt),
    .uart_match    (uart_match),
    .uart_mask     (uart_mask),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .trig_addr     (trig_addr),
    .armed         (armed),
    .capture_done  (capture_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model
  int m_baud, m_match, m_mask, m_trig_en, m_trig_pos;
  int m_wr_addr, m_trig_addr;
  bit m_active;      // capture in flight (PRE/WAIT/POST)
  bit m_done;        // capture finished, awaiting arm/abort
  bit m_trig_seen;
  int m_pre_left;    // pre-trigger samples still owed
  int m_post_left;   // post-trigger samples still owed

  task automatic model_reset();
    m_baud = 0; m_match = 0; m_mask = 0; m_trig_en = 0; m_trig_pos = 0;
    m_wr_addr = 0; m_trig_addr = 0;
    m_active = 0; m_done = 0; m_trig_seen = 0;
    m_pre_left = 0; m_post_left = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic take_sample();
    m_wr_addr = (m_wr_addr + 1) % DEPTH;
  endtask

  // Called at a negedge with inputs already driven: compare outputs, advance
  // the model across the coming posedge, then clear the one-cycle pulses.
  task automatic tick();
    bit act_now;
    #1;
    check("wr_en",        wr_en,         m_active && smpl_en && !abort);
    check("wr_addr",      wr_addr,       m_wr_addr);
    check("trig_addr",    trig_addr,     m_trig_addr);
    check("armed",        armed,         m_active);
    check("capture_done", capture_done,  m_done);
    check("uart_baud",    uart_baud_cnt, m_baud);
    check("uart_match",   uart_match,    m_match);
    check("uart_mask",    uart_mask,     m_mask);

    act_now = m_active;
    if (abort) begin
      m_active = 0;
      m_done   = 0;
    end else if (!m_active) begin
      if (arm) begin
        m_wr_addr   = 0;
        m_active    = 1;
        m_done      = 0;
        m_trig_seen = 0;
        m_pre_left  = m_trig_pos;
        m_post_left = DEPTH - m_trig_pos;
      end
    end else if (m_pre_left > 0) begin
      if (smpl_en) begin
        take_sample();
        m_pre_left--;
      end
    end else if (!m_trig_seen) begin
      if ((trig_src & m_trig_en[N_SRC-1:0]) != 0) begin
        m_trig_addr = m_wr_addr;
        m_trig_seen = 1;
        if (smpl_en) begin
          take_sample();
          m_post_left--;
          if (m_post_left == 0) begin m_active = 0; m_done = 1; end
        end
      end else if (smpl_en) begin
        take_sample();
      end
    end else if (smpl_en) begin
      take_sample();
      m_post_left--;
      if (m_post_left == 0) begin m_active = 0; m_done = 1; end
    end

    if (cfg_wr && !act_now) begin
      case (cfg_addr)
        2'd0: m_baud = cfg_wdata;
        2'd1: begin m_mask = cfg_wdata[15:8]; m_match = cfg_wdata[7:0]; end
        2'd2: m_trig_en = cfg_wdata % (1 << N_SRC);
        default: m_trig_pos = cfg_wdata % DEPTH;
      endcase
    end

    @(negedge clk);
    cyc++;
    arm = 0; abort = 0; cfg_wr = 0; trig_src = '0;
  endtask

  task automatic cfg(input logic [1:0] a, input logic [15:0] d);
    cfg_wr = 1; cfg_addr = a; cfg_wdata = d;
    tick();
  endtask

  initial begin
    int n_strobe;
    int guard;
    rst_n = 0; cfg_wr = 0; cfg_addr = 0; cfg_wdata = 0;
    arm = 0; abort = 0; smpl_en = 0; trig_src = '0;
    model_reset();

    // Reset state
    @(negedge clk);
    check("rst_armed", armed, 0);
    check("rst_done",  capture_done, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_addr",  wr_addr, 0);
    rst_n = 1;
    @(negedge clk);

    // UART config writes in IDLE
    cfg(2'd0, 16'h01B2);
    cfg(2'd1, 16'hF0A5);
    check("cfg_baud",  uart_baud_cnt, 16'h01B2);
    check("cfg_mask",  uart_mask, 8'hF0);
    check("cfg_match", uart_match, 8'hA5);

    // Normal capture: trig_pos=4, trig_en=1, smpl_en always high
    smpl_en = 1;
    cfg(2'd2, 16'h0001);
    cfg(2'd3, 16'h0004);
    arm = 1; tick();
    repeat (4) tick();
    check("norm_wait_armed", armed, 1);
    repeat (5) tick();
    check("norm_addr9", wr_addr, 9);
    trig_src = 4'b0001; tick();
    check("norm_trig_addr", trig_addr, 9);
    repeat (10) tick();
    check("norm_not_done", capture_done, 0);
    tick();
    check("norm_done",  capture_done, 1);
    check("norm_wr_en", wr_en, 0);
    check("norm_wrap_addr", wr_addr, 5);

    // trig_pos=0: straight to WAIT, 16 post writes
    cfg(2'd3, 16'h0000);
    arm = 1; tick();
    check("tp0_armed", armed, 1);
    repeat (2) tick();
    trig_src = 4'b0001; tick();
    check("tp0_trig_addr", trig_addr, 2);
    repeat (14) tick();
    check("tp0_not_done", capture_done, 0);
    check("tp0_last_addr", wr_addr, 1);
    tick();
    check("tp0_done", capture_done, 1);

    // Masking, PRE guard, config lockout, arm in POST, abort in POST
    cfg(2'd2, 16'h0002);
    cfg(2'd3, 16'h0003);
    arm = 1; tick();
    trig_src = 4'b0011; tick();
    check("pre_guard_trig_addr", trig_addr, 2);
    repeat (2) tick();
    trig_src = 4'b0001; cfg_wr = 1; cfg_addr = 2'd3; cfg_wdata = 16'h0009; tick();
    check("mask_still_waiting", armed, 1);
    check("mask_trig_addr_held", trig_addr, 2);
    trig_src = 4'b0010; tick();
    check("mask_src1_trig", trig_addr, 4);
    tick();
    arm = 1; tick();
    check("arm_in_post_armed", armed, 1);
    abort = 1;
    #1 check("abort_wr_en", wr_en, 0);
    tick();
    check("abort_idle",    armed, 0);
    check("abort_no_done", capture_done, 0);
    check("abort_addr_hold", wr_addr, 7);
    tick();
    check("abort_done_stays0", capture_done, 0);

    // Sparse sampling: smpl_en every 3rd cycle, trig_pos=2, off-strobe trigger.
    // trig_pos was locked at 3 above; post count of 14 also proves the rewrite.
    cfg(2'd3, 16'h0002);
    cfg(2'd2, 16'h0001);
    smpl_en = (cyc % 3 == 0);
    arm = 1; tick();
    guard = 0;
    while (!(m_active && m_pre_left == 0 && (cyc % 3) != 0) && guard < 60) begin
      smpl_en = (cyc % 3 == 0);
      tick();
      guard++;
    end
    check("sparse_reach_wait", guard < 60, 1);
    smpl_en = 0; trig_src = 4'b0001; tick();
    n_strobe = 0;
    guard = 0;
    while (capture_done !== 1'b1 && guard < 200) begin
      smpl_en = (cyc % 3 == 0);
      if (smpl_en) n_strobe++;
      tick();
      guard++;
    end
    check("sparse_done", capture_done, 1);
    check("sparse_post_strobes", n_strobe, 14);

    // Asynchronous reset mid-POST
    smpl_en = 1;
    arm = 1; tick();
    repeat (2) tick();
    trig_src = 4'b0001; tick();
    repeat (3) tick();
    check("pre_rst_armed", armed, 1);
    rst_n = 0;
    #1;
    check("mrst_armed",     armed, 0);
    check("mrst_done",      capture_done, 0);
    check("mrst_wr_en",     wr_en, 0);
    check("mrst_wr_addr",   wr_addr, 0);
    check("mrst_trig_addr", trig_addr, 0);
    check("mrst_baud",      uart_baud_cnt, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    // Randomized phase against the model
    for (int i = 0; i < 1500; i++) begin
      smpl_en  = ($urandom_range(0, 3) != 0);
      trig_src = ($urandom_range(0, 9) == 0) ? 4'($urandom) : 4'b0000;
      arm      = ($urandom_range(0, 24) == 0);
      abort    = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 11) == 0) begin
        cfg_wr    = 1;
        cfg_addr  = 2'($urandom);
        cfg_wdata = 16'($urandom);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
